// File: rtl/key_uart_tx.sv
// Keypad-to-UART bridge: change-detects key_val, queues characters, sends 8N1 frames.
// Define UART_PARITY_EN to insert an even-parity bit and send 8E1 frames.
module key_uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    key_val,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int CW         = AW + 1;
    localparam int BW         = $clog2(BIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_tx, w_tx_nxt;
    logic            r_busy;
    logic            r_ovf;
    logic [7:0]      r_prev;
    logic [BW-1:0]   r_baud, w_baud_nxt;
    logic [2:0]      r_bit, w_bit_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr, r_rd;
    logic [CW-1:0]   r_count, w_count_nxt;
`ifdef UART_PARITY_EN
    logic            r_par;
`endif

    logic w_push_req, w_full, w_push, w_pop, w_drop, w_baud_end;

    assign w_push_req = (key_val != r_prev) && (key_val != 8'h00);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_baud_end = (r_baud == BW'(BIT_CYCLES - 1));

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_baud_nxt  = r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_tx_nxt    = r_par;
                        w_state_nxt = S_PARITY;
`else
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    // back-to-back: next start bit follows the stop bit directly
                    if (r_count != '0) begin
                        w_pop       = 1'b1;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_pop)
            w_shift_nxt = r_mem[r_rd];
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= key_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_prev  <= 8'h00;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
            r_prev  <= key_val;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
            if (w_drop)
                r_ovf <= 1'b1;
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_par <= 1'b0;
        else if (w_pop)
            r_par <= ^r_mem[r_rd];
    end
`endif

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_count = r_count;
    assign overflow   = r_ovf;

endmodule
